// File: rtl/floo_pkg.sv
// Shared FlooNoC helpers used by the link cut and the router VC arbitration.
package floo_pkg;

    // Physical lane carrying virtual channel v: a single shared lane, or one lane per VC.
    function automatic int unsigned vc_lane(input int unsigned v, input int unsigned num_phys);
        return (num_phys == 1) ? 0 : v;
    endfunction

endpackage

// File: rtl/floo_vc_cut_fifo.sv
// Single-VC circular FIFO for the link cut: flop storage, head visible from registers.
module floo_vc_cut_fifo #(
    parameter int unsigned BufDepth = 2,
    parameter type         flit_t   = logic
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push_i,
    input  flit_t                           data_i,
    input  logic                            pop_i,
    output logic [$clog2(BufDepth+1)-1:0]   cnt_o,
    output flit_t                           head_o
);
    localparam int unsigned CntW = $clog2(BufDepth + 1);
    localparam int unsigned PtrW = (BufDepth > 1) ? $clog2(BufDepth) : 1;

    flit_t            mem_q [BufDepth];
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    // Pointers wrap at BufDepth-1 so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(BufDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next pointer/occupancy state; simultaneous push and pop leaves the count unchanged.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push_i && !pop_i) cnt_d = cnt_q + 1'b1;
        if (pop_i && !push_i) cnt_d = cnt_q - 1'b1;
    end

    // Control state register; reset empties the FIFO and blocks any push/pop at that edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Flit storage is never reset; only written on an accepted push.
    always_ff @(posedge clk_i) begin
        if (push_i && !rst_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign cnt_o  = cnt_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/floo_vc_link_cut.sv
// Registered VC link stage: per-VC FIFOs, ready_o from flops only, VC re-arbitration
// onto one shared lane or one lane per VC.
module floo_vc_link_cut
    import floo_pkg::*;
#(
    parameter int unsigned NumVirtChannels = 1,
    parameter int unsigned NumPhysChannels = 1,
    parameter int unsigned BufDepth        = 2,
    parameter type         flit_t          = logic
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumVirtChannels-1:0]    valid_i,
    output logic [NumVirtChannels-1:0]    ready_o,
    input  flit_t [NumPhysChannels-1:0]   data_i,
    output logic [NumVirtChannels-1:0]    valid_o,
    input  logic [NumVirtChannels-1:0]    ready_i,
    output flit_t [NumPhysChannels-1:0]   data_o
);
    localparam int unsigned CntW = $clog2(BufDepth + 1);
    localparam int unsigned VcW  = (NumVirtChannels > 1) ? $clog2(NumVirtChannels) : 1;

    if (!(NumPhysChannels == 1 || NumPhysChannels == NumVirtChannels)) begin : g_bad_lanes
        $fatal(1, "floo_vc_link_cut: NumPhysChannels must be 1 or NumVirtChannels");
    end
    if (BufDepth < 1) begin : g_bad_depth
        $fatal(1, "floo_vc_link_cut: BufDepth must be at least 1");
    end

    logic [CntW-1:0]             cnt  [NumVirtChannels];
    flit_t                       head [NumVirtChannels];
    logic [NumVirtChannels-1:0]  push_req, push, pop, cand;
    logic [NumVirtChannels-1:0]  stall_q;

    for (genvar gi = 0; gi < NumVirtChannels; gi++) begin : g_vc
        assign ready_o[gi] = (cnt[gi] != CntW'(BufDepth));
        assign cand[gi]    = (cnt[gi] != '0) && ready_i[gi];

        floo_vc_cut_fifo #(
            .BufDepth (BufDepth),
            .flit_t   (flit_t)
        ) u_fifo (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .push_i (push[gi]),
            .data_i (data_i[vc_lane(gi, NumPhysChannels)]),
            .pop_i  (pop[gi]),
            .cnt_o  (cnt[gi]),
            .head_o (head[gi])
        );
    end

    assign push_req = valid_i & ready_o;

    if (NumPhysChannels == 1) begin : g_shared
        logic [VcW-1:0]             rr_q, rr_d, sel_q, sel_d, gnt_idx, mux_idx;
        logic                       gnt_any;
        logic [NumVirtChannels-1:0] gnt;

        // A shared lane carries one flit per cycle: keep only the lowest requesting VC.
        assign push = push_req & (~push_req + 1'b1);

        // Round-robin grant: first candidate at or above rr_q, else wrap to the lowest.
        always_comb begin
            gnt     = '0;
            gnt_idx = '0;
            gnt_any = 1'b0;
            for (int v = 0; v < NumVirtChannels; v++) begin
                if (!gnt_any && cand[v] && (VcW'(v) >= rr_q)) begin
                    gnt_any = 1'b1;
                    gnt_idx = VcW'(v);
                    gnt[v]  = 1'b1;
                end
            end
            for (int v = 0; v < NumVirtChannels; v++) begin
                if (!gnt_any && cand[v]) begin
                    gnt_any = 1'b1;
                    gnt_idx = VcW'(v);
                    gnt[v]  = 1'b1;
                end
            end
            rr_d    = rr_q;
            sel_d   = sel_q;
            if (gnt_any) begin
                rr_d  = (gnt_idx == VcW'(NumVirtChannels - 1)) ? '0 : gnt_idx + 1'b1;
                sel_d = gnt_idx;
            end
            mux_idx = gnt_any ? gnt_idx : sel_q;
            data_o[0] = head[0];
            for (int v = 0; v < NumVirtChannels; v++) begin
                if (VcW'(v) == mux_idx) data_o[0] = head[v];
            end
        end

        // Arbiter pointer and last-selected VC (so an idle lane keeps showing that head).
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rr_q  <= '0;
                sel_q <= '0;
            end else begin
                rr_q  <= rr_d;
                sel_q <= sel_d;
            end
        end

        assign valid_o = gnt;
        assign pop     = gnt;
    end else begin : g_lanes
        assign push    = push_req;
        assign valid_o = cand;
        assign pop     = cand;
        for (genvar gi = 0; gi < NumVirtChannels; gi++) begin : g_out
            assign data_o[gi] = head[gi];
        end
    end

    // Remember VCs that offered a flit we refused, to check upstream keeps it offered.
    always_ff @(posedge clk_i) begin
        if (rst_i) stall_q <= '0;
        else       stall_q <= valid_i & ~ready_o;
    end

    // Protocol and occupancy checks; silent while reset is applied.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int v = 0; v < NumVirtChannels; v++) begin
                assert (!(pop[v] && cnt[v] == '0))
                    else $error("floo_vc_link_cut: pop from empty FIFO on VC %0d", v);
                assert (!(push[v] && cnt[v] == CntW'(BufDepth)))
                    else $error("floo_vc_link_cut: push to full FIFO on VC %0d", v);
                assert (!(stall_q[v] && !valid_i[v]))
                    else $error("floo_vc_link_cut: valid_i dropped while not ready on VC %0d", v);
            end
            if (NumPhysChannels == 1) begin
                assert ($onehot0(valid_o))
                    else $error("floo_vc_link_cut: valid_o not one-hot on shared lane");
                assert ($onehot0(valid_i))
                    else $error("floo_vc_link_cut: several valid_i on shared lane");
            end
        end
    end

endmodule

// File: tb/tb_floo_vc_link_cut.sv
// Bench for floo_vc_link_cut: a shared-lane instance (2 VCs, 1 lane) and a lane-per-VC
// instance (2 VCs, 2 lanes), both depth 2, checked cycle by cycle against queue models.
module tb_floo_vc_link_cut;
    localparam int NV = 2;
    localparam int BD = 2;
    typedef logic [7:0] flit_t;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              rst_i;
    logic [NV-1:0]     a_valid_i, a_ready_o, a_valid_o, a_ready_i;
    flit_t [0:0]       a_data_i, a_data_o;
    logic [NV-1:0]     b_valid_i, b_ready_o, b_valid_o, b_ready_i;
    flit_t [NV-1:0]    b_data_i, b_data_o;

    floo_vc_link_cut #(
        .NumVirtChannels (NV),
        .NumPhysChannels (1),
        .BufDepth        (BD),
        .flit_t          (flit_t)
    ) u_dut_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (a_valid_i),
        .ready_o (a_ready_o),
        .data_i  (a_data_i),
        .valid_o (a_valid_o),
        .ready_i (a_ready_i),
        .data_o  (a_data_o)
    );

    floo_vc_link_cut #(
        .NumVirtChannels (NV),
        .NumPhysChannels (NV),
        .BufDepth        (BD),
        .flit_t          (flit_t)
    ) u_dut_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .valid_i (b_valid_i),
        .ready_o (b_ready_o),
        .data_i  (b_data_i),
        .valid_o (b_valid_o),
        .ready_i (b_ready_i),
        .data_o  (b_data_o)
    );

    // Reference state: buffered flits per VC, upstream flits waiting to be sent.
    flit_t qa [NV][$];
    flit_t qb [NV][$];
    flit_t pa [NV][$];
    flit_t pb [NV][$];
    int    rr_a;
    int    act_a;
    bit    known;
    int    total;
    int    bad;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int v, input flit_t d);
        pa[v].push_back(d);
        pb[v].push_back(d);
    endtask

    // One clock cycle: drive upstream, check outputs mid-cycle, advance the model at the edge.
    task automatic step();
        logic [NV-1:0] rdy_a, rdy_b, vb, ga;
        int g;
        int s;
        rdy_a = '0; rdy_b = '0; vb = '0; ga = '0; g = -1;
        if (act_a < 0) begin
            s = $urandom_range(0, NV - 1);
            for (int i = 0; i < NV; i++) begin
                int v;
                v = (s + i) % NV;
                if (act_a < 0 && pa[v].size() > 0) act_a = v;
            end
        end
        a_valid_i   = '0;
        a_data_i[0] = 8'($urandom);
        if (act_a >= 0) begin
            a_valid_i[act_a] = 1'b1;
            a_data_i[0]      = pa[act_a][0];
        end
        for (int v = 0; v < NV; v++) begin
            b_valid_i[v] = (pb[v].size() > 0);
            b_data_i[v]  = (pb[v].size() > 0) ? pb[v][0] : 8'($urandom);
        end
        #4;
        for (int v = 0; v < NV; v++) begin
            rdy_a[v] = (qa[v].size() < BD);
            rdy_b[v] = (qb[v].size() < BD);
            vb[v]    = (qb[v].size() > 0) && b_ready_i[v];
        end
        for (int i = 0; i < NV; i++) begin
            int idx;
            idx = (rr_a + i) % NV;
            if (g < 0 && qa[idx].size() > 0 && a_ready_i[idx]) g = idx;
        end
        if (g >= 0) ga[g] = 1'b1;
        if (known) begin
            chk("a_ready_o", 8'(a_ready_o), 8'(rdy_a));
            chk("a_valid_o", 8'(a_valid_o), 8'(ga));
            if (g >= 0) chk("a_data_o", a_data_o[0], qa[g][0]);
            chk("b_ready_o", 8'(b_ready_o), 8'(rdy_b));
            chk("b_valid_o", 8'(b_valid_o), 8'(vb));
            for (int v = 0; v < NV; v++) begin
                if (vb[v]) chk($sformatf("b_data_o%0d", v), b_data_o[v], qb[v][0]);
            end
        end
        @(posedge clk_i);
        if (rst_i) begin
            for (int v = 0; v < NV; v++) begin
                qa[v].delete();
                qb[v].delete();
            end
            rr_a  = 0;
            known = 1'b1;
        end else if (known) begin
            if (g >= 0) begin
                void'(qa[g].pop_front());
                rr_a = (g + 1) % NV;
            end
            if (act_a >= 0 && rdy_a[act_a]) begin
                qa[act_a].push_back(pa[act_a].pop_front());
                act_a = -1;
            end
            for (int v = 0; v < NV; v++) begin
                if (vb[v]) void'(qb[v].pop_front());
                if (b_valid_i[v] && rdy_b[v]) qb[v].push_back(pb[v].pop_front());
            end
        end
        #1;
    endtask

    initial begin
        rst_i     = 1'b1;
        a_valid_i = '0; a_ready_i = '0; a_data_i = '0;
        b_valid_i = '0; b_ready_i = '0; b_data_i = '0;
        act_a = -1; rr_a = 0; known = 1'b0; total = 0; bad = 0;
        @(posedge clk_i);
        #1;

        // Reset held two cycles, then idle.
        step();
        step();
        rst_i = 1'b0;
        repeat (3) step();

        // Back-to-back stream on VC0.
        a_ready_i = 2'b11; b_ready_i = 2'b11;
        for (int i = 0; i < 8; i++) send(0, flit_t'(8'h10 + i));
        repeat (12) step();

        // Backpressure on VC1, then release.
        a_ready_i = 2'b01; b_ready_i = 2'b01;
        for (int i = 0; i < 3; i++) send(1, flit_t'(8'h20 + i));
        repeat (5) step();
        a_ready_i = 2'b11; b_ready_i = 2'b11;
        repeat (6) step();

        // Preload both VCs, then drain with round-robin.
        a_ready_i = 2'b00; b_ready_i = 2'b00;
        for (int i = 0; i < 4; i++) begin
            send(0, flit_t'(8'h40 + i));
            send(1, flit_t'(8'h50 + i));
        end
        repeat (6) step();
        a_ready_i = 2'b11; b_ready_i = 2'b11;
        repeat (14) step();

        // Simultaneous pushes on both VCs.
        send(0, 8'hA0);
        send(1, 8'hB0);
        repeat (3) step();

        // Reset with two flits buffered on VC0, then a fresh flit.
        a_ready_i = 2'b00; b_ready_i = 2'b00;
        send(0, 8'h61);
        send(0, 8'h62);
        repeat (3) step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        send(0, 8'h55);
        a_ready_i = 2'b11; b_ready_i = 2'b11;
        repeat (3) step();

        // Random traffic with random downstream readiness.
        for (int n = 0; n < 400; n++) begin
            a_ready_i = 2'($urandom);
            b_ready_i = 2'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                int v;
                v = $urandom_range(0, NV - 1);
                if (pa[v].size() < 4 && pb[v].size() < 4) send(v, 8'($urandom));
            end
            step();
        end
        a_ready_i = 2'b11; b_ready_i = 2'b11;
        repeat (30) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
